// File: rtl/reduce_pkt_pkg.sv
// rtl/reduce_pkt_pkg.sv - shared types and sizing for the reduce packetizer
package reduce_pkt_pkg;

    localparam int DEF_NUM_THREADS = 8;
    localparam int DEF_NUM_LANES   = 2;
    localparam int DEF_XLEN        = 32;
    localparam int DEF_UUID_WIDTH  = 1;
    localparam int DEF_NW_WIDTH    = 1;
    localparam int DEF_NR_BITS     = 5;
    localparam int DEF_OP_BITS     = 4;

    function automatic int pid_width(input int num_packets);
        return (num_packets > 1) ? $clog2(num_packets) : 1;
    endfunction

    localparam int NUM_PACKETS = DEF_NUM_THREADS / DEF_NUM_LANES;
    localparam int PID_W       = pid_width(NUM_PACKETS);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [DEF_UUID_WIDTH-1:0] uuid;
        logic [DEF_NW_WIDTH-1:0]   wid;
        logic [DEF_XLEN-1:0]       pc;
        logic [DEF_OP_BITS-1:0]    op_type;
        logic [DEF_NR_BITS-1:0]    rd;
        logic                      wb;
    } hdr_t;

endpackage

// File: rtl/reduce_pkt_find.sv
// rtl/reduce_pkt_find.sv - lowest nonzero packet index at or above a start pid
module reduce_pkt_find #(
    parameter int NUM_PACKETS = 4,
    parameter int PID_W       = 2
) (
    input  logic [NUM_PACKETS-1:0] nz,
    input  logic [PID_W:0]         start,
    output logic [PID_W-1:0]       next_pid,
    output logic                   found,
    output logic                   is_last
);

    logic higher;

    always_comb begin
        found    = 1'b0;
        next_pid = '0;
        higher   = 1'b0;
        // Descending scan so the lowest qualifying index wins.
        for (int p = NUM_PACKETS - 1; p >= 0; p--) begin
            if (nz[p] && (p >= int'(start))) begin
                found    = 1'b1;
                next_pid = PID_W'(p);
            end
        end
        for (int p = 0; p < NUM_PACKETS; p++) begin
            if (nz[p] && (p > int'(next_pid))) begin
                higher = found;
            end
        end
        is_last = found && !higher;
    end

endmodule

// File: rtl/reduce_packetizer.sv
// rtl/reduce_packetizer.sv - splits one warp reduce instruction into lane-group packets
// REDUCE_PKT_SKIP_EN: skip packets whose thread-mask slice is all zero.
module reduce_packetizer
    import reduce_pkt_pkg::*;
#(
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int XLEN        = DEF_XLEN,
    parameter int UUID_WIDTH  = DEF_UUID_WIDTH,
    parameter int NW_WIDTH    = DEF_NW_WIDTH,
    parameter int NR_BITS     = DEF_NR_BITS,
    parameter int OP_BITS     = DEF_OP_BITS,
    localparam int NPKT       = NUM_THREADS / NUM_LANES,
    localparam int PW         = pid_width(NPKT)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [UUID_WIDTH-1:0]         in_uuid,
    input  logic [NW_WIDTH-1:0]           in_wid,
    input  logic [NUM_THREADS-1:0]        in_tmask,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [OP_BITS-1:0]            in_op_type,
    input  logic [NR_BITS-1:0]            in_rd,
    input  logic                          in_wb,
    input  logic [NUM_THREADS*XLEN-1:0]   in_rs1_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [UUID_WIDTH-1:0]         out_uuid,
    output logic [NW_WIDTH-1:0]           out_wid,
    output logic [XLEN-1:0]               out_pc,
    output logic [OP_BITS-1:0]            out_op_type,
    output logic [NR_BITS-1:0]            out_rd,
    output logic                          out_wb,
    output logic [NUM_LANES-1:0]          out_tmask,
    output logic [NUM_LANES*XLEN-1:0]     out_rs1_data,
    output logic [PW-1:0]                 out_pid,
    output logic                          out_sop,
    output logic                          out_eop
);

    state_e                      state_q, state_d;
    logic [PW-1:0]               pid_q, pid_d;
    logic                        sop_q, sop_d;
    logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
    logic [NUM_THREADS*XLEN-1:0] data_q, data_d;
    hdr_t                        hdr_q, hdr_d;

    logic          eop;
    logic          fire;
    logic          capture;
    logic [PW-1:0] cap_pid;
    logic [PW-1:0] next_pid;

`ifdef REDUCE_PKT_SKIP_EN
    logic [NPKT-1:0] nz_in;
    logic [NPKT-1:0] nz_held;
    logic [PW:0]     start_next;
    logic [PW-1:0]   first_pid;
    logic            cap_found;
    logic            adv_found;
    logic            unused_cap_last;
    logic            unused_adv_last;

    for (genvar p = 0; p < NPKT; p++) begin : g_nz
        assign nz_in[p]   = |in_tmask[p*NUM_LANES +: NUM_LANES];
        assign nz_held[p] = |tmask_q[p*NUM_LANES +: NUM_LANES];
    end

    assign start_next = {1'b0, pid_q} + (PW+1)'(1);

    reduce_pkt_find #(.NUM_PACKETS(NPKT), .PID_W(PW)) u_find_first (
        .nz       (nz_in),
        .start    ('0),
        .next_pid (first_pid),
        .found    (cap_found),
        .is_last  (unused_cap_last)
    );

    reduce_pkt_find #(.NUM_PACKETS(NPKT), .PID_W(PW)) u_find_next (
        .nz       (nz_held),
        .start    (start_next),
        .next_pid (next_pid),
        .found    (adv_found),
        .is_last  (unused_adv_last)
    );

    // An all-zero mask still yields one packet at pid 0.
    assign cap_pid = cap_found ? first_pid : '0;
    assign eop     = !adv_found;
`else
    assign cap_pid  = '0;
    assign next_pid = pid_q + PW'(1);
    assign eop      = (pid_q == PW'(NPKT - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = EMIT;
            EMIT: if (fire && eop && !in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == EMIT);
        in_ready  = (state_q == IDLE) || (out_ready && eop);
        fire      = out_valid && out_ready;
        capture   = in_valid && in_ready;
    end

    always_comb begin
        pid_d   = pid_q;
        sop_d   = sop_q;
        tmask_d = tmask_q;
        data_d  = data_q;
        hdr_d   = hdr_q;
        if (capture) begin
            pid_d   = cap_pid;
            sop_d   = 1'b1;
            tmask_d = in_tmask;
            data_d  = in_rs1_data;
            hdr_d   = '{uuid: in_uuid, wid: in_wid, pc: in_pc, op_type: in_op_type,
                        rd: in_rd, wb: in_wb};
        end else if (fire && !eop) begin
            pid_d = next_pid;
            sop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pid_q   <= '0;
            sop_q   <= 1'b0;
            tmask_q <= '0;
            data_q  <= '0;
            hdr_q   <= '0;
        end else begin
            pid_q   <= pid_d;
            sop_q   <= sop_d;
            tmask_q <= tmask_d;
            data_q  <= data_d;
            hdr_q   <= hdr_d;
        end
    end

    assign out_uuid     = hdr_q.uuid;
    assign out_wid      = hdr_q.wid;
    assign out_pc       = hdr_q.pc;
    assign out_op_type  = hdr_q.op_type;
    assign out_rd       = hdr_q.rd;
    assign out_wb       = hdr_q.wb;
    assign out_tmask    = tmask_q[pid_q*NUM_LANES +: NUM_LANES];
    assign out_rs1_data = data_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    assign out_pid      = pid_q;
    assign out_sop      = sop_q;
    assign out_eop      = eop;

endmodule

// File: tb/tb_reduce_packetizer.sv
// tb/tb_reduce_packetizer.sv - scoreboard bench for reduce_packetizer
module tb_reduce_packetizer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [0:0]   in_uuid;
    logic [0:0]   in_wid;
    logic [7:0]   in_tmask;
    logic [31:0]  in_pc;
    logic [3:0]   in_op_type;
    logic [4:0]   in_rd;
    logic         in_wb;
    logic [255:0] in_rs1_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:0]   out_uuid;
    logic [0:0]   out_wid;
    logic [31:0]  out_pc;
    logic [3:0]   out_op_type;
    logic [4:0]   out_rd;
    logic         out_wb;
    logic [1:0]   out_tmask;
    logic [63:0]  out_rs1_data;
    logic [1:0]   out_pid;
    logic         out_sop;
    logic         out_eop;

    reduce_packetizer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_uuid      (in_uuid),
        .in_wid       (in_wid),
        .in_tmask     (in_tmask),
        .in_pc        (in_pc),
        .in_op_type   (in_op_type),
        .in_rd        (in_rd),
        .in_wb        (in_wb),
        .in_rs1_data  (in_rs1_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_uuid     (out_uuid),
        .out_wid      (out_wid),
        .out_pc       (out_pc),
        .out_op_type  (out_op_type),
        .out_rd       (out_rd),
        .out_wb       (out_wb),
        .out_tmask    (out_tmask),
        .out_rs1_data (out_rs1_data),
        .out_pid      (out_pid),
        .out_sop      (out_sop),
        .out_eop      (out_eop)
    );

    always #5 clk = ~clk;

    // {pid, sop, eop, tmask, data, uuid, wid, pc, op_type, rd, wb}
    logic [113:0] cur;
    assign cur = {out_pid, out_sop, out_eop, out_tmask, out_rs1_data, out_uuid, out_wid,
                  out_pc, out_op_type, out_rd, out_wb};

    logic [113:0] sb[$];
    int  vectors    = 0;
    int  miscompares = 0;
    bit  rdy_rand   = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_push();
        int ids[$];
        logic [113:0] e;
        for (int p = 0; p < 4; p++) begin
`ifdef REDUCE_PKT_SKIP_EN
            if (in_tmask[p*2 +: 2] != 2'b00) ids.push_back(p);
`else
            ids.push_back(p);
`endif
        end
        if (ids.size() == 0) ids.push_back(0);
        for (int k = 0; k < ids.size(); k++) begin
            e = {2'(ids[k]), (k == 0), (k == ids.size() - 1), in_tmask[ids[k]*2 +: 2],
                 in_rs1_data[ids[k]*64 +: 64], in_uuid, in_wid, in_pc, in_op_type, in_rd, in_wb};
            sb.push_back(e);
        end
    endfunction

    // Monitor: packet compare on fire, plus latency and stall stability rules.
    bit           lat_pend = 1'b0;
    bit           stall_prev = 1'b0;
    logic [113:0] snap;
    logic [113:0] exp_pkt;
    always @(negedge clk) begin
        if (!reset) begin
            lat_pend   = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (lat_pend)
                chk(out_valid && out_sop, "first_pkt_latency", {out_valid, out_sop}, 2'b11);
            if (stall_prev)
                chk(cur == snap, "stall_stable", cur, snap);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_pkt", cur, 0);
                end else begin
                    exp_pkt = sb.pop_front();
                    chk(cur == exp_pkt, "packet", cur, exp_pkt);
                end
            end
            if (out_valid && !out_ready)
                chk(!in_ready, "in_ready_stall", in_ready, 0);
            stall_prev = out_valid && !out_ready;
            snap       = cur;
            lat_pend   = in_valid && in_ready;
        end
    end

    always @(posedge clk) begin
        if (rdy_rand) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Entered and left at posedge+1.
    task automatic send(input logic [7:0] tm, input logic [255:0] d, input bit b2b);
        bit ok = 1'b0;
        in_uuid     = 1'($urandom);
        in_wid      = 1'($urandom);
        in_pc       = $urandom;
        in_op_type  = 4'($urandom);
        in_rd       = 5'($urandom);
        in_wb       = 1'($urandom);
        in_tmask    = tm;
        in_rs1_data = d;
        in_valid    = 1'b1;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                model_push();
                if (b2b)
                    chk(out_valid && out_ready && out_eop && out_pid == 2'd3, "b2b_accept",
                        {out_valid, out_ready, out_eop, out_pid}, 5'b11111);
            end
        end
        if (!ok) chk(1'b0, "accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        chk(done, "drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    logic [255:0] seq_data;
    logic [7:0]   tm;

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_uuid     = '0;
        in_wid      = '0;
        in_tmask    = '0;
        in_pc       = '0;
        in_op_type  = '0;
        in_rd       = '0;
        in_wb       = 1'b0;
        in_rs1_data = '0;
        out_ready   = 1'b1;
        for (int i = 0; i < 8; i++) seq_data[i*32 +: 32] = 32'(i + 1);

        repeat (3) @(negedge clk);
        chk(!out_valid && in_ready, "reset_handshake", {out_valid, in_ready}, 2'b01);
        chk(cur == '0, "reset_held", cur, 0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;

        // Full mask, sequential lanes, ready always high.
        send(8'hFF, seq_data, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk(out_valid && out_pid == 2'(k), "consecutive_pid", {out_valid, out_pid},
                {1'b1, 2'(k)});
        end
        @(posedge clk);
        #1;
        drain();

        // Stall on pid 1 for three cycles.
        out_ready = 1'b0;
        send(8'hFF, rand_data(), 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();

        // Back-to-back with in_valid held.
        send(8'hFF, rand_data(), 1'b0);
        send(8'h5A, rand_data(), 1'b1);
        drain();

        send(8'h00, rand_data(), 1'b0);
        drain();
        send(8'b0011_0000, rand_data(), 1'b0);
        drain();

        // Reset while pid 1 is pending.
        out_ready = 1'b0;
        send(8'hFF, rand_data(), 1'b0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk(!out_valid && in_ready, "async_reset", {out_valid, in_ready}, 2'b01);
        chk(cur == '0, "async_reset_held", cur, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk(!out_valid, "reset_hold_quiet", out_valid, 0);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(8'hFF, rand_data(), 1'b0);
        drain();

        // Randomised traffic with random backpressure.
        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0:       tm = 8'h00;
                1:       tm = 8'hFF;
                2:       tm = 8'($urandom);
                default: tm = 8'(32'($urandom_range(1, 3)) << (2 * $urandom_range(0, 3)));
            endcase
            send(tm, rand_data(), 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rdy_rand = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reduce_packetizer.md
Name: reduce_packetizer

Overview:
- Upstream neighbour of the warp reduce unit. Accepts one warp-wide reduce instruction carrying `NUM_THREADS` lanes of rs1 data and a thread mask.
- Serialises it into `NUM_THREADS/NUM_LANES` lane-group packets, each tagged with pid/sop/eop, on a valid/ready stream. The reduce unit's execute side consumes this stream.
- Holds one instruction at a time. Uses a small FSM and a packet counter.

Parameters:
- NUM_THREADS, 8, lanes per warp; must be a multiple of NUM_LANES.
- NUM_LANES, 2, lanes per emitted packet.
- XLEN, 32, data width per lane.
- UUID_WIDTH, 1, instruction uuid width.
- NW_WIDTH, 1, warp id width.
- NR_BITS, 5, register index width.
- OP_BITS, 4, reduce op_type width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  instruction accept.
- in_uuid  in  UUID_WIDTH  instruction uuid.
- in_wid  in  NW_WIDTH  warp id.
- in_tmask  in  NUM_THREADS  thread mask.
- in_pc  in  XLEN  instruction PC.
- in_op_type  in  OP_BITS  reduce op.
- in_rd  in  NR_BITS  destination register.
- in_wb  in  1  writeback enable.
- in_rs1_data  in  NUM_THREADS*XLEN  operand, lane i at bits [i*XLEN +: XLEN].
- out_valid  out  1  packet valid.
- out_ready  in  1  packet accept.
- out_uuid, out_wid, out_pc, out_op_type, out_rd, out_wb  out  as inputs  held copies of the instruction fields.
- out_tmask  out  NUM_LANES  mask slice for the current packet.
- out_rs1_data  out  NUM_LANES*XLEN  data slice for the current packet.
- out_pid  out  PID_W=max(1,clog2(NUM_THREADS/NUM_LANES))  packet index.
- out_sop  out  1  first emitted packet of the instruction.
- out_eop  out  1  last emitted packet of the instruction.

Behaviour:
- Reset (asserted low, asynchronous):
  - state=IDLE, out_valid=0, in_ready=1.
  - pid counter=0, all held fields=0.
- FSM states: IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid is high, register all in_* fields and go to EMIT. The first packet is valid the next cycle, giving 1-cycle latency.
- EMIT:
  - out_valid=1.
  - Output slices come from the held data at index pid: tmask bits [pid*NUM_LANES +: NUM_LANES], data likewise.
  - Outputs are stable while out_valid && !out_ready.
- Packet walk:
  - On an out fire that is not eop: pid advances to the next packet to emit, and sop clears.
  - On an out fire with eop: return to IDLE.
- Back-to-back instructions:
  - in_ready is also 1 in EMIT in the cycle the eop packet fires.
  - If in_valid is also high that cycle, capture the new instruction and stay in EMIT with pid reset to its first packet. There is no bubble.
- sop is 1 only on the first emitted packet. eop is 1 only on the last emitted packet.
- Single-packet case (NUM_THREADS==NUM_LANES): one packet with sop=eop=1, pid=0.
- All-zero in_tmask: exactly one packet is still emitted, with pid=0, sop=eop=1, out_tmask=0. Never zero packets.
- Held fields change only on capture. A reset mid-instruction drops the instruction with no further out_valid.

Optional Feature:
- Macro: REDUCE_PKT_SKIP_EN.
- Defined:
  - Packets whose tmask slice is all zero are not emitted.
  - The first packet is the lowest pid with a nonzero slice; the next packet is the next-higher nonzero pid.
  - eop is set on the highest nonzero pid.
  - Emitted pid values are therefore not contiguous.
  - The all-zero-mask rule above still applies.
- Undefined: every pid 0..NUM_PACKETS-1 is emitted in order, sop at pid 0, eop at the last pid.

Decomposition:
- Package reduce_pkt_pkg holds:
  - the NUM_PACKETS and PID_W localparams;
  - the state typedef (IDLE, EMIT);
  - the packed header struct for uuid, wid, pc, op_type, rd and wb.
- One sub-module, reduce_pkt_find. It is combinational and used only under REDUCE_PKT_SKIP_EN.
  - Inputs: a per-packet nonzero vector and a start pid.
  - Outputs: the next nonzero pid at or above start, a found flag, and an is_last flag.

Test Plan (NUM_THREADS=8, NUM_LANES=2, XLEN=32, out_ready=1 unless noted):
1. Full mask, lanes hold values 1..8 -> 4 packets on consecutive cycles:
   - pid 0,1,2,3 with data {1,2},{3,4},{5,6},{7,8};
   - sop only on pid 0, eop only on pid 3;
   - first out_valid 1 cycle after in fire.
2. out_ready held low 3 cycles on pid 1 -> outputs and pid stay stable; in_ready=0 throughout; then pids 2 and 3 follow.
3. Two back-to-back instructions with in_valid high continuously -> the second is accepted in the cycle pid 3 fires; its pid 0 appears the next cycle with no gap.
4. in_tmask=8'h00 -> exactly one packet: pid 0, sop=eop=1, out_tmask=2'b00.
5. With REDUCE_PKT_SKIP_EN, in_tmask=8'b0011_0000 -> a single packet pid 2, sop=eop=1, tmask=2'b11. Without the macro -> 4 packets, pid 2 carries tmask 2'b11.
6. reset driven low while pid=1 is pending -> out_valid drops immediately (asynchronously); after release, in_ready=1 and the next instruction starts at pid 0 with sop=1.
